// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared widths, store entry type and writeback FSM states
// Purpose: default data/address widths for the data-memory path, the
//          {addr, data} store entry at those widths, and the writeback
//          output FSM state encoding.
// Ports:   none (package)
package mm_pkg;

  localparam int MM_DATA_W = 16;
  localparam int MM_ADDR_W = 12;

  typedef struct packed {
    logic [MM_ADDR_W-1:0] addr;
    logic [MM_DATA_W-1:0] data;
  } mm_store_t;

  typedef enum logic {
    WB_IDLE  = 1'b0,
    WB_WRITE = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO buffering accepted store entries
// Purpose: DEPTH-entry first-word-fall-through FIFO; head entry is always
//          visible on pop_data while not empty.
// Ports:   clk, rst (sync, active high)
//          push, push_data  - write side (ignored when full)
//          pop, pop_data    - read side (ignored when empty)
//          full, empty, count - occupancy status
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 28
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/acc_writeback.sv
// rtl/acc_writeback.sv - round-robin drain of core accumulator stores into data memory
// Purpose: arbitrates per-core store requests round-robin, buffers accepted
//          stores in a FIFO and issues them in acceptance order to the
//          memory write port under a ready handshake.
// Ports:   clk, rst (sync, active high)
//          core_req/core_data/core_addr - packed per-core store requests
//          core_ack   - combinational one-hot grant, store taken at that edge
//          mem_wr_en/mem_addr/mem_wr_data - registered write port
//          mem_ready  - write retires at an edge with mem_wr_en && mem_ready
//          busy, fifo_count - status
module acc_writeback
  import mm_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int DATA_W     = MM_DATA_W,
  parameter int ADDR_W     = MM_ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          core_req,
  input  logic [NUM_CORES*DATA_W-1:0]   core_data,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
  output logic [NUM_CORES-1:0]          core_ack,
  output logic                          mem_wr_en,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wr_data,
  input  logic                          mem_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  function automatic logic [IW-1:0] wrap_idx(input int v);
    return IW'(v % NUM_CORES);
  endfunction

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] cand;
  logic          found;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  entry_t        push_entry;
  entry_t        head_entry;
  wb_state_e     state;

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand = wrap_idx(int'(rr_ptr) + i);
      if (!found && core_req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Full blocks acceptance even when the output side pops this cycle.
  assign push     = found && !fifo_full && !rst;
  assign core_ack = push ? (NUM_CORES'(1) << gnt_idx) : '0;

  assign push_entry.addr = core_addr[gnt_idx*ADDR_W +: ADDR_W];
  assign push_entry.data = core_data[gnt_idx*DATA_W +: DATA_W];

  // Head is taken when the output register is free or retiring this edge.
  assign pop  = !rst && !fifo_empty && ((state == WB_IDLE) || mem_ready);
  assign busy = (fifo_count != '0) || mem_wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= wrap_idx(int'(gnt_idx) + 1);
    end
  end

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WB_IDLE;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
    end else begin
      case (state)
        WB_IDLE: begin
          if (!fifo_empty) begin
            mem_addr    <= head_entry.addr;
            mem_wr_data <= head_entry.data;
            mem_wr_en   <= 1'b1;
            state       <= WB_WRITE;
          end
        end
        WB_WRITE: begin
          if (mem_ready) begin
            if (!fifo_empty) begin
              mem_addr    <= head_entry.addr;
              mem_wr_data <= head_entry.data;
            end else begin
              mem_wr_en <= 1'b0;
              state     <= WB_IDLE;
            end
          end
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_writeback.sv
// tb/tb_acc_writeback.sv - scoreboard bench for acc_writeback
module tb_acc_writeback;

  localparam int NC = 4;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam int FD = 4;

  logic              clk;
  logic              rst;
  logic [NC-1:0]     core_req;
  logic [NC*DW-1:0]  core_data;
  logic [NC*AW-1:0]  core_addr;
  logic [NC-1:0]     core_ack;
  logic              mem_wr_en;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wr_data;
  logic              mem_ready;
  logic              busy;
  logic [2:0]        fifo_count;

  acc_writeback #(
    .NUM_CORES (NC), .DATA_W (DW), .ADDR_W (AW), .FIFO_DEPTH (FD)
  ) dut (
    .clk (clk), .rst (rst), .core_req (core_req), .core_data (core_data),
    .core_addr (core_addr), .core_ack (core_ack), .mem_wr_en (mem_wr_en),
    .mem_addr (mem_addr), .mem_wr_data (mem_wr_data), .mem_ready (mem_ready),
    .busy (busy), .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-core pending store lists (ring buffers), front is what the core presents.
  logic [AW-1:0] sa [NC][64];
  logic [DW-1:0] sd [NC][64];
  int            wi [NC];
  int            ri [NC];
  logic [NC-1:0] ack_seen;

  function automatic int pending(input int c);
    return wi[c] - ri[c];
  endfunction

  task automatic drive();
    for (int c = 0; c < NC; c++) begin
      core_req[c] = (pending(c) != 0);
      core_addr[c*AW +: AW] = sa[c][ri[c] % 64];
      core_data[c*DW +: DW] = sd[c][ri[c] % 64];
    end
  endtask

  task automatic add_store(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    sa[c][wi[c] % 64] = a;
    sd[c][wi[c] % 64] = d;
    wi[c]++;
    drive();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int c = 0; c < NC; c++) if (ack_seen[c]) ri[c]++;
    drive();
  endtask

  task automatic flush_sources();
    for (int c = 0; c < NC; c++) ri[c] = wi[c];
    drive();
  endtask

  // Reference model: a list of accepted-but-not-yet-issued stores, one
  // output slot that frees on mem_ready, and a rotating priority start.
  logic [AW+DW-1:0] exp_q [$];
  int               m_fifo;
  bit               m_out;
  int               m_rr;
  bit               chk_on = 0;

  always @(negedge clk) begin
    int g;
    bit pop_m;
    bit ret_m;
    logic [NC-1:0] exp_ack;
    ack_seen = core_ack;
    g = -1;
    if (!rst && chk_on && m_fifo < FD)
      for (int k = 0; k < NC; k++)
        if (g < 0 && core_req[(m_rr + k) % NC]) g = (m_rr + k) % NC;
    exp_ack = (g >= 0) ? NC'(1) << g : '0;
    if (rst) begin
      chk("ack_in_reset", 32'(core_ack), 32'd0);
    end else if (chk_on) begin
      chk("core_ack", 32'(core_ack), 32'(exp_ack));
      chk("fifo_count", 32'(fifo_count), 32'(m_fifo));
      chk("mem_wr_en", 32'(mem_wr_en), 32'(m_out));
      chk("busy", 32'(busy), 32'((m_fifo != 0) || m_out));
    end
    if (rst) begin
      m_fifo = 0;
      m_out  = 0;
      m_rr   = 0;
      exp_q.delete();
      chk_on = 1;
    end else if (chk_on) begin
      pop_m = (m_fifo > 0) && (!m_out || mem_ready);
      ret_m = m_out && mem_ready;
      if (g >= 0) begin
        exp_q.push_back({core_addr[g*AW +: AW], core_data[g*DW +: DW]});
        m_rr = (g + 1) % NC;
        m_fifo++;
      end
      if (pop_m) m_fifo--;
      if (pop_m) m_out = 1;
      else if (ret_m) m_out = 0;
    end
  end

  // Monitor: whatever is on the write port must be the oldest unretired store.
  always @(negedge clk) begin
    logic [AW+DW-1:0] front;
    if (chk_on && !rst && mem_wr_en) begin
      if (exp_q.size() == 0) begin
        chk("write_without_store", 32'(mem_wr_en), 32'd0);
      end else begin
        front = exp_q[0];
        chk("wr_addr", 32'(mem_addr), 32'(front[AW+DW-1:DW]));
        chk("wr_data", 32'(mem_wr_data), 32'(front[DW-1:0]));
        if (mem_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    bit done;
    for (int c = 0; c < NC; c++) begin wi[c] = 0; ri[c] = 0; end
    ack_seen  = '0;
    core_req  = '0;
    core_data = '0;
    core_addr = '0;
    mem_ready = 1'b1;
    rst       = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_mem_wr_data", 32'(mem_wr_data), 32'd0);

    // single store from core1
    add_store(1, 12'h010, 16'd200);
    repeat (5) step();

    // all cores requesting continuously
    for (int c = 0; c < NC; c++)
      for (int j = 0; j < 3; j++) add_store(c, AW'(16 * c + j), DW'(1000 + 10 * c + j));
    repeat (16) step();

    // backpressure until full, then release
    mem_ready = 1'b0;
    for (int j = 0; j < 6; j++) add_store(0, AW'(12'h100 + j), DW'(20 + 5 * j));
    repeat (10) step();
    mem_ready = 1'b1;
    repeat (10) step();

    // stall hold on a single write
    add_store(2, 12'h222, 16'd300);
    step();
    mem_ready = 1'b0;
    repeat (3) step();
    mem_ready = 1'b1;
    repeat (3) step();

    // reset with buffered and outstanding stores
    mem_ready = 1'b0;
    for (int j = 0; j < 4; j++) add_store(3, AW'(12'h300 + j), DW'(400 + j));
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_ready = 1'b1;
    step();
    add_store(1, 12'h045, 16'd450);
    repeat (5) step();

    // randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NC; c++)
        if (pending(c) < 3 && $urandom_range(0, 3) == 0)
          add_store(c, AW'($urandom), DW'($urandom));
      mem_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    mem_ready = 1'b1;

    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      if (!busy && core_req == '0) done = 1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout actual=busy required=idle");
      flush_sources();
    end
    @(negedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_writeback.md
Name: acc_writeback

Overview:
Drains accumulator results from the N processing cores into the shared data memory; it is the consumer end of the accumulator's dataOut path. Each core raises a store request carrying its accumulator value and a target address. The block arbitrates round-robin, buffers accepted stores in a small FIFO, and issues them one at a time to the memory write port under a ready handshake.

Parameters:
NUM_CORES, 4, number of core store-request channels
DATA_W, 16, accumulator/memory word width
ADDR_W, 12, data-memory address width
FIFO_DEPTH, 4, buffered store entries (power of two, >=2)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
core_req  input  NUM_CORES  per-core store request; held until acked
core_data  input  NUM_CORES*DATA_W  per-core accumulator value, core i at bits [i*DATA_W +: DATA_W]
core_addr  input  NUM_CORES*ADDR_W  per-core target address, same packing
core_ack  output  NUM_CORES  combinational one-hot grant; store captured at the edge where ack is high
mem_wr_en  output  1  registered memory write strobe
mem_addr  output  ADDR_W  registered write address
mem_wr_data  output  DATA_W  registered write data
mem_ready  input  1  memory accepts the write at an edge where mem_wr_en && mem_ready
busy  output  1  FIFO non-empty or write outstanding
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=1 at edge): FIFO emptied, fifo_count=0, rr pointer=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, busy=0. Mid-operation reset discards buffered and outstanding stores; mem_wr_en is low in the cycle after the reset edge.
- Arbitration: core_ack is at most one-hot. Grant goes to the first requester at or after rr pointer, wrapping modulo NUM_CORES. core_ack=0 when FIFO full (fifo_count==FIFO_DEPTH) or rst=1.
- Full blocks acceptance even if a pop occurs in the same cycle.
- On an accepted push, rr pointer becomes (granted index + 1) mod NUM_CORES; otherwise it holds.
- Core side: a core keeps req/data/addr stable until it samples ack high at an edge, then may drop req or present a new store the next cycle.
- FIFO: entry = {addr, data}. Push and pop in the same cycle leave the count unchanged. Pointers wrap at FIFO_DEPTH.
- Output FSM, two states:
  - IDLE: mem_wr_en=0. If FIFO non-empty, pop head into the output registers, set mem_wr_en=1, go to WRITE.
  - WRITE: hold mem_wr_en/addr/data stable while mem_ready=0.
  - WRITE on mem_ready=1 edge: if FIFO non-empty, pop the next entry and stay in WRITE (back-to-back, one write per cycle); else mem_wr_en=0, go to IDLE.
- Latency: store accepted at edge k appears on mem_wr_en/mem_addr/mem_wr_data after edge k+1 when IDLE and empty.
- Ordering: memory writes occur in exact acceptance order.
- busy = (fifo_count!=0) || mem_wr_en.
- No arithmetic on data; width preserved bit-exact.

Decomposition:
- Shared package (mm_pkg): DATA_W/ADDR_W defaults, store entry struct {addr, data}, FSM state enum WB_IDLE/WB_WRITE.
- One sub-module: wb_fifo (synchronous FIFO, DEPTH/WIDTH params, push/pop/full/empty/count).
- Round-robin arbiter stays inline.

Test Plan:
- Single store: core1 req addr=0x010 data=200, mem_ready=1 -> core_ack=0010 same cycle; mem_wr_en high 2 cycles later with addr 0x010 data 200 for exactly 1 cycle; busy then 0.
- Round-robin: all 4 cores request continuously, mem_ready=1 -> acks in order core0,1,2,3,0; writes appear in the same order, one per cycle, no gaps.
- Backpressure/full: mem_ready=0, core0 issues 6 stores (data 20,25,30,35,40,45) -> first 5 accepted (4 in FIFO + 1 in output register), 6th ack held low, fifo_count=4; set mem_ready=1 -> all 6 written in order 20..45.
- Stall hold: mem_ready low for 3 cycles during a write of data 300 -> mem_addr/mem_wr_data stable all 3 cycles; retires on the first ready edge.
- Reset mid-operation: 3 entries buffered plus 1 outstanding, assert rst for 1 cycle -> mem_wr_en=0, fifo_count=0, busy=0 next cycle; subsequent store of 450 written correctly.
- Simultaneous push/pop at count=2 -> count stays 2, no data lost or duplicated (scoreboard check).
